// File: rtl/run_sequencer_if.sv
// Run-control signal bundle between the top-level controller and run_sequencer.
// master drives start/entry_pc/inst; slave (the sequencer) drives the core controls and status.
interface run_sequencer_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 9,
    parameter int CNT_W  = 16
) ();
    logic              start;
    logic [PC_W-1:0]   entry_pc;
    logic [INST_W-1:0] inst;
    logic              core_rst;
    logic              core_en;
    logic              pc_load;
    logic [PC_W-1:0]   pc_load_val;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output start, entry_pc, inst,
        input  core_rst, core_en, pc_load, pc_load_val, done, timed_out, cycle_cnt
    );

    modport slave (
        input  start, entry_pc, inst,
        output core_rst, core_en, pc_load, pc_load_val, done, timed_out, cycle_cnt
    );
endinterface

// File: rtl/run_sequencer.sv
// Run-control FSM for the mips_u core: holds it in reset, loads the entry PC,
// runs until the halt instruction or the watchdog fires, then reports done.
module run_sequencer #(
    parameter int                PC_W     = 8,
    parameter int                INST_W   = 9,
    parameter logic [INST_W-1:0] HALT_OP  = 9'h1FF,
    parameter int                INIT_CYC = 2,
    parameter int                TIMEOUT  = 4096,
    parameter int                CNT_W    = 16
) (
    input logic             clk,
    input logic             rst,
    run_sequencer_if.slave  bus
);
    localparam int               INIT_W       = $clog2(INIT_CYC + 1);
    localparam logic [INIT_W-1:0] INIT_LAST   = INIT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [INIT_W-1:0] init_cnt;
    logic              halt_hit;
    logic              limit_hit;
    logic [CNT_W-1:0]  cnt_next;

    assign halt_hit  = (bus.inst == HALT_OP);
    assign limit_hit = (bus.cycle_cnt == TIMEOUT_LAST);
    assign cnt_next  = (&bus.cycle_cnt) ? bus.cycle_cnt : bus.cycle_cnt + 1'b1;

    // NOTE: non-blocking assignments everywhere here, so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            init_cnt        <= '0;
            bus.core_rst    <= 1'b1;
            bus.core_en     <= 1'b0;
            bus.pc_load     <= 1'b0;
            bus.pc_load_val <= PC_W'(0);
            bus.done        <= 1'b0;
            bus.timed_out   <= 1'b0;
            bus.cycle_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.core_rst <= 1'b1;
                    bus.core_en  <= 1'b0;
                    bus.pc_load  <= 1'b0;
                    bus.done     <= 1'b0;
                    if (bus.start) begin
                        state           <= S_INIT;
                        bus.pc_load_val <= bus.entry_pc;
                        bus.cycle_cnt   <= '0;
                        bus.timed_out   <= 1'b0;
                        init_cnt        <= INIT_LAST;
                    end
                end

                S_INIT: begin
                    if (init_cnt == '0) begin
                        state        <= S_LOAD;
                        bus.core_rst <= 1'b0;
                        bus.pc_load  <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt - 1'b1;
                    end
                end

                S_LOAD: begin
                    state       <= S_RUN;
                    bus.pc_load <= 1'b0;
                    bus.core_en <= 1'b1;
                end

                S_RUN: begin
                    // The halting cycle is still counted; halt outranks the watchdog.
                    bus.cycle_cnt <= cnt_next;
                    if (halt_hit) begin
                        state       <= S_DONE;
                        bus.core_en <= 1'b0;
                        bus.done    <= 1'b1;
                    end else if (limit_hit) begin
                        state         <= S_DONE;
                        bus.core_en   <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.timed_out <= 1'b1;
                    end
                end

                S_DONE: begin
                    // Core stays out of reset so its state can be inspected.
                    if (!bus.start) begin
                        state        <= S_IDLE;
                        bus.done     <= 1'b0;
                        bus.core_rst <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with TIMEOUT=16, INIT_CYC=2.
module tb_run_sequencer;
    localparam logic [8:0] HALT = 9'h1FF;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    run_sequencer_if #(.PC_W(8), .INST_W(9), .CNT_W(16)) bus ();

    run_sequencer #(
        .PC_W(8), .INST_W(9), .HALT_OP(HALT), .INIT_CYC(2), .TIMEOUT(16), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts from IDLE with start=1 already applied; runs until done or a cycle budget expires.
    task automatic do_run(input int halt_at, input bit drop_start,
                          output int pulses, output int latency, output int run_cycles,
                          output logic [7:0] load_val, output logic [15:0] first_cnt,
                          output bit ok);
        int edges;
        pulses     = 0;
        latency    = 0;
        run_cycles = 0;
        load_val   = 8'h00;
        first_cnt  = 16'hFFFF;
        ok         = 1'b0;
        edges      = 0;
        bus.inst   = 9'h0FF;
        for (int i = 0; i < 200; i++) begin
            step();
            edges++;
            if (edges == 1) begin
                first_cnt = bus.cycle_cnt;
                if (drop_start) bus.start = 1'b0;
            end
            if (bus.pc_load) begin
                pulses++;
                load_val = bus.pc_load_val;
            end
            if (bus.core_en && latency == 0) latency = edges;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.core_en) begin
                run_cycles++;
                bus.inst = (run_cycles == halt_at) ? HALT
                         : ((run_cycles % 2 == 1) ? 9'h1FE : 9'h0FF);
            end else begin
                bus.inst = 9'h0FF;
            end
        end
        bus.inst = 9'h0FF;
    endtask

    int          pulses, latency, run_cycles, held;
    logic [7:0]  load_val;
    logic [15:0] first_cnt;
    bit          ok;

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b1;
        bus.entry_pc = 8'h10;
        bus.inst     = 9'h0FF;

        // Reset held with start asserted
        step();
        step();
        check("rst_core_rst", bus.core_rst, 1);
        check("rst_core_en", bus.core_en, 0);
        check("rst_pc_load", bus.pc_load, 0);
        check("rst_pc_val", bus.pc_load_val, 0);
        check("rst_done", bus.done, 0);
        check("rst_timed_out", bus.timed_out, 0);
        check("rst_cycle_cnt", bus.cycle_cnt, 0);

        // Halt on 5th RUN cycle
        rst = 1'b1;
        do_run(5, 1'b0, pulses, latency, run_cycles, load_val, first_cnt, ok);
        check("h5_done_seen", ok, 1);
        check("h5_pulses", pulses, 1);
        check("h5_load_val", load_val, 8'h10);
        check("h5_latency", latency, 4);
        check("h5_run_cycles", run_cycles, 5);
        check("h5_cycle_cnt", bus.cycle_cnt, 5);
        check("h5_timed_out", bus.timed_out, 0);
        check("h5_core_en", bus.core_en, 0);
        check("h5_core_rst", bus.core_rst, 0);

        // start held in DONE never re-runs
        held = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done && !bus.core_en && !bus.pc_load && !bus.core_rst) held++;
        end
        check("hold_done_cycles", held, 10);
        check("hold_cycle_cnt", bus.cycle_cnt, 5);
        bus.start = 1'b0;
        step();
        check("idle_done", bus.done, 0);
        check("idle_core_rst", bus.core_rst, 1);
        check("idle_cnt_kept", bus.cycle_cnt, 5);

        // Watchdog run: no halt ever
        bus.start    = 1'b1;
        bus.entry_pc = 8'h2A;
        do_run(0, 1'b0, pulses, latency, run_cycles, load_val, first_cnt, ok);
        check("to_cnt_cleared", first_cnt, 0);
        check("to_done_seen", ok, 1);
        check("to_load_val", load_val, 8'h2A);
        check("to_run_cycles", run_cycles, 16);
        check("to_cycle_cnt", bus.cycle_cnt, 16);
        check("to_timed_out", bus.timed_out, 1);
        check("to_core_en", bus.core_en, 0);

        // Halt and watchdog on the same cycle, start dropped mid-run
        bus.start = 1'b0;
        step();
        check("to_idle_done", bus.done, 0);
        bus.start    = 1'b1;
        bus.entry_pc = 8'h33;
        do_run(16, 1'b1, pulses, latency, run_cycles, load_val, first_cnt, ok);
        check("h16_done_seen", ok, 1);
        check("h16_timed_out", bus.timed_out, 0);
        check("h16_cycle_cnt", bus.cycle_cnt, 16);
        check("h16_load_val", load_val, 8'h33);
        check("h16_pulses", pulses, 1);

        // Halt on the very first RUN cycle
        step();
        check("h1_idle", bus.done, 0);
        bus.start    = 1'b1;
        bus.entry_pc = 8'h01;
        do_run(1, 1'b0, pulses, latency, run_cycles, load_val, first_cnt, ok);
        check("h1_done_seen", ok, 1);
        check("h1_cycle_cnt", bus.cycle_cnt, 1);
        check("h1_timed_out", bus.timed_out, 0);

        // Reset during RUN cycle 3
        bus.start = 1'b0;
        step();
        bus.start    = 1'b1;
        bus.entry_pc = 8'h44;
        bus.inst     = 9'h0FF;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.core_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("r6_run_seen", ok, 1);
        step();
        step();
        check("r6_cnt_before", bus.cycle_cnt, 2);
        check("r6_pc_val_before", bus.pc_load_val, 8'h44);
        rst = 1'b0;
        step();
        check("r6_core_rst", bus.core_rst, 1);
        check("r6_core_en", bus.core_en, 0);
        check("r6_done", bus.done, 0);
        check("r6_cycle_cnt", bus.cycle_cnt, 0);
        check("r6_pc_val", bus.pc_load_val, 0);
        rst = 1'b1;
        step();
        check("r6_restart_core_rst", bus.core_rst, 1);
        check("r6_restart_pc_val", bus.pc_load_val, 8'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
